// File: rtl/mmio_timer_if.sv
// mmio_timer_if -- data-memory-port bus between the M stage and the timer.
//
// Signals:
//   addr        byte address (bits [1:0] are not used by the timer)
//   byte_en     per-byte write enables, 4'b0000 means read or no access
//   write_data  store data, already lane-aligned
//   read_data   combinational read data returned by the responder
//
// Access protocol: there is no valid/ready pair. Every cycle is an access.
// A cycle with byte_en != 0 is a store that commits on the next rising edge.
// A cycle with byte_en == 0 is a load whose read_data is valid in the same
// cycle. The responder never stalls.
//
// Modports: master = CPU side (drives the request), slave = timer side.

interface mmio_timer_if;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output addr,
        output byte_en,
        output write_data,
        input  read_data
    );

    modport slave (
        input  addr,
        input  byte_en,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer -- memory-mapped countdown timer on the M-stage data bus.
//
// Register window (16 bytes at BASE_ADDR, offset = addr[3:2]):
//   0 CTRL   R/W  {28'b0, IM, MODE[1:0], EN}
//   1 PRESET R/W  reload value, byte-writable
//   2 COUNT  RO   current count
//   3 reserved; with MMIO_TIMER_STATUS_EN defined it is STATUS:
//            read {28'b0, pending, state[1:0], EN}, write 1 to bit0 clears pending
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   bus        mmio_timer_if.slave (addr, byte_en, write_data, read_data)
//   irq        registered interrupt request (pending & IM)
//   state_dbg  current FSM state, IDLE=0 LOAD=1 CNT=2 INT=3
//
// Optional feature macro: MMIO_TIMER_STATUS_EN (STATUS register at offset 3).

module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h00007F00
) (
    input  logic             clk,
    input  logic             reset,
    mmio_timer_if.slave      bus,
    output logic             irq,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        hit;
    logic [1:0]  offset;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        im_nxt;
    logic        pending_nxt;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = bus.addr[3:2];
    assign wr          = hit && (bus.byte_en != 4'b0000);
    assign wr_ctrl     = wr && (offset == 2'd0);
    assign wr_preset   = wr && (offset == 2'd1);
    // MODE 1x behaves like one-shot, so only 01 selects reload.
    assign auto_reload = (ctrl_mode == 2'b01);
    assign state_dbg   = state;

    // Word-addressed registers: the byte offset inside a word is irrelevant.
    assign unused_addr_bits = ^bus.addr[1:0];

`ifdef MMIO_TIMER_STATUS_EN
    logic wr_status_clr;
    assign wr_status_clr = wr && (offset == 2'd3) && bus.byte_en[0] && bus.write_data[0];
`endif

    // IM as it will be after this edge, so irq tracks a CTRL write without
    // an extra cycle of lag while still being a pure register output.
    assign im_nxt = (wr_ctrl && bus.byte_en[0]) ? bus.write_data[3] : ctrl_im;

    // Clears are applied first; the set on INT entry is last so it wins any
    // same-cycle clear.
    always_comb begin
        pending_nxt = pending;
        if (wr_ctrl) begin
            pending_nxt = 1'b0;
        end
`ifdef MMIO_TIMER_STATUS_EN
        if (wr_status_clr) begin
            pending_nxt = 1'b0;
        end
`endif
        if ((state == ST_INT) && auto_reload) begin
            pending_nxt = 1'b0;
        end
        if ((state == ST_CNT) && ctrl_en && (count <= 32'd1)) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= 32'd0;
            count     <= 32'd0;
            pending   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // PRESET 0 and 1 both expire here.
                        count <= 32'd0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload && ctrl_en) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                    if (!auto_reload) begin
                        ctrl_en <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // CPU write comes after the FSM so its EN value wins a tie.
            if (wr_ctrl && bus.byte_en[0]) begin
                ctrl_en   <= bus.write_data[0];
                ctrl_mode <= bus.write_data[2:1];
                ctrl_im   <= bus.write_data[3];
            end

            if (wr_preset) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.byte_en[i]) begin
                        preset[8*i +: 8] <= bus.write_data[8*i +: 8];
                    end
                end
            end

            pending <= pending_nxt;
            irq     <= pending_nxt & im_nxt;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (hit) begin
            case (offset)
                2'd0: rd_mux = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
                2'd1: rd_mux = preset;
                2'd2: rd_mux = count;
`ifdef MMIO_TIMER_STATUS_EN
                2'd3: rd_mux = {28'd0, pending, state_dbg, ctrl_en};
`else
                2'd3: rd_mux = 32'd0;
`endif
                default: rd_mux = 32'd0;
            endcase
        end
    end

    assign bus.read_data = rd_mux;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer -- directed plus randomized bench for mmio_timer with a
// behavioural model that is stepped on every rising edge and compared
// against the DUT on every falling edge.

module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h00007F00;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;
`ifdef MMIO_TIMER_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_timer_if bus_if ();
    logic       irq;
    logic [1:0] state_dbg;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus_if.slave),
        .irq       (irq),
        .state_dbg (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;
    bit compare_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en = 0;
    logic [1:0]  m_mode = 0;
    bit          m_im = 0;
    logic [31:0] m_preset = 0;
    logic [31:0] m_count = 0;
    int          m_phase = PH_IDLE;
    bit          m_pending = 0;
    bit          m_irq = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if ((a & 32'hFFFF_FFF0) != BASE) return 32'd0;
        case ((a >> 2) & 32'd3)
            0: return {28'd0, m_im, m_mode, m_en};
            1: return m_preset;
            2: return m_count;
            default: return STATUS_ON ? {28'd0, m_pending, 2'(m_phase), m_en} : 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] a = bus_if.addr;
        logic [3:0]  be = bus_if.byte_en;
        logic [31:0] wd = bus_if.write_data;
        bit    hit = ((a & 32'hFFFF_FFF0) == BASE);
        int    off = int'((a >> 2) & 32'd3);
        bit    wr = hit && (be != 4'd0);
        bit    reload = (m_mode == 2'b01);
        int    ph = m_phase;
        bit    pend = m_pending;
        bit    expire = 1'b0;
        logic [31:0] cnt = m_count;
        bit    en = m_en;
        logic [1:0] mode = m_mode;
        bit    im = m_im;
        logic [31:0] pre = m_preset;

        if (m_phase == PH_IDLE && m_en) ph = PH_LOAD;
        else if (m_phase == PH_LOAD) begin
            cnt = m_preset;
            ph = PH_CNT;
        end else if (m_phase == PH_CNT) begin
            if (!m_en) ph = PH_IDLE;
            else if (m_count > 1) cnt = m_count - 1;
            else begin
                cnt = 0;
                ph = PH_INT;
                expire = 1'b1;
            end
        end else if (m_phase == PH_INT) begin
            ph = (reload && m_en) ? PH_LOAD : PH_IDLE;
            if (!reload) en = 1'b0;
            else pend = 1'b0;
        end

        if (wr && off == 0) begin
            pend = 1'b0;
            if (be[0]) begin
                en = wd[0];
                mode = wd[2:1];
                im = wd[3];
            end
        end
        if (wr && off == 1) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) pre[8*i +: 8] = wd[8*i +: 8];
        end
        if (STATUS_ON && wr && off == 3 && be[0] && wd[0]) pend = 1'b0;
        if (expire) pend = 1'b1;

        m_phase = ph; m_count = cnt; m_en = en; m_mode = mode; m_im = im;
        m_preset = pre; m_pending = pend; m_irq = pend & im;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = 0; m_mode = 0; m_im = 0; m_preset = 0; m_count = 0;
            m_phase = PH_IDLE; m_pending = 0; m_irq = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (compare_on) begin
            check("read_data", bus_if.read_data, model_read(bus_if.addr));
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            check("state", {30'd0, state_dbg}, 32'(m_phase));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus_if.addr = a;
        bus_if.byte_en = be;
        bus_if.write_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [3:0] be, input logic [31:0] wd);
        cyc(BASE + 32'(off * 4), be, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(BASE + 32'd8, 4'd0, 32'd0);
    endtask

    task automatic rd_irq(input string name, input int off, input logic [31:0] exp_d, input logic exp_irq);
        bus_if.addr = BASE + 32'(off * 4);
        bus_if.byte_en = 4'd0;
        bus_if.write_data = $urandom;
        #1;
        check({name, "_data"}, bus_if.read_data, exp_d);
        check({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [3:0]  be;
        int r;
        bus_if.addr = 32'd0;
        bus_if.byte_en = 4'd0;
        bus_if.write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_on = 1'b1;
        rd_irq("rst_ctrl0", 0, 32'd0, 1'b0);
        rd_irq("rst_cnt0", 2, 32'd0, 1'b0);

        // One-shot, PRESET=3, IM set.
        wr(1, 4'hF, 32'd3);
        wr(0, 4'hF, 32'h9);
        idle(2);
        rd_irq("os_c3", 2, 32'd3, 1'b0);
        rd_irq("os_c2", 2, 32'd2, 1'b0);
        rd_irq("os_c1", 2, 32'd1, 1'b0);
        rd_irq("os_c0", 2, 32'd0, 1'b1);
        rd_irq("os_ctrl", 0, 32'h8, 1'b1);
        wr(0, 4'hF, 32'd0);
        rd_irq("os_clr", 0, 32'd0, 1'b0);

        // Auto-reload, PRESET=2: period 4, one-cycle irq pulses.
        wr(1, 4'hF, 32'd2);
        wr(0, 4'hF, 32'hB);
        idle(2);
        rd_irq("ar_a", 2, 32'd2, 1'b0);
        rd_irq("ar_b", 2, 32'd1, 1'b0);
        rd_irq("ar_c", 2, 32'd0, 1'b1);
        rd_irq("ar_d", 2, 32'd0, 1'b0);
        rd_irq("ar_e", 2, 32'd2, 1'b0);
        rd_irq("ar_f", 2, 32'd1, 1'b0);
        rd_irq("ar_g", 2, 32'd0, 1'b1);
        rd_irq("ar_h", 2, 32'd0, 1'b0);
        wr(0, 4'hF, 32'd0);
        idle(2);

        // Clear EN so the FSM sees it with COUNT=7, then re-enable.
        wr(1, 4'hF, 32'd10);
        wr(0, 4'hF, 32'h1);
        idle(4);
        wr(0, 4'hF, 32'd0);
        idle(1);
        rd_irq("hold7", 2, 32'd7, 1'b0);
        check("hold_state", {30'd0, state_dbg}, 32'd0);
        wr(0, 4'hF, 32'h1);
        idle(2);
        rd_irq("reload10", 2, 32'd10, 1'b0);
        wr(0, 4'hF, 32'd0);
        idle(1);

        // Byte lanes, read-only COUNT, unstored CTRL bits, miss.
        wr(1, 4'hF, 32'h11223344);
        wr(1, 4'b0010, 32'h0000AB00);
        rd_irq("bytew", 1, 32'h1122AB44, 1'b0);
        wr(2, 4'hF, 32'h0000DEAD);
        rd_irq("cnt_ro", 2, 32'd8, 1'b0);
        wr(0, 4'hF, 32'hFFFF_FFF0);
        rd_irq("ctrl_hi", 0, 32'd0, 1'b0);
        wr(0, 4'hE, 32'h0000_000F);
        rd_irq("ctrl_b0", 0, 32'd0, 1'b0);
        rd_irq("miss", 4, 32'd0, 1'b0);

        // One-shot expiry then STATUS access.
        wr(1, 4'hF, 32'd1);
        wr(0, 4'hF, 32'h9);
        idle(3);
        rd_irq("st_int", 2, 32'd0, 1'b1);
        rd_irq("status", 3, STATUS_ON ? 32'h8 : 32'h0, 1'b1);
        wr(3, 4'h1, 32'h1);
        rd_irq("w1c", 0, 32'h8, !STATUS_ON);
        wr(0, 4'hF, 32'd0);
        idle(1);

        // Asynchronous reset mid-count at COUNT=5.
        wr(1, 4'hF, 32'd20);
        wr(0, 4'hF, 32'h9);
        idle(17);
        bus_if.addr = BASE + 32'd8;
        bus_if.byte_en = 4'd0;
        #1;
        check("pre_rst_cnt", bus_if.read_data, 32'd5);
        rst_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_state", {30'd0, state_dbg}, 32'd0);
        check("arst_cnt", bus_if.read_data, 32'd0);
        bus_if.addr = BASE + 32'd4;
        #1;
        check("arst_pre", bus_if.read_data, 32'd0);
        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;
        rd_irq("post_ctrl", 0, 32'd0, 1'b0);
        rd_irq("post_cnt", 2, 32'd0, 1'b0);

        // Randomized traffic, checked by the compare process.
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                cyc(BASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)), 4'd0, $urandom);
            end else if (r < 50) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                wr(0, be, d);
            end else if (r < 65) begin
                be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(1, 15));
                wr(1, be, 32'($urandom_range(0, 6)));
            end else if (r < 80) begin
                wr(2 + $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom);
            end else if (r < 90) begin
                cyc(BASE + 32'd16 + 32'($urandom_range(0, 64)), 4'($urandom_range(0, 15)), $urandom);
            end else begin
                cyc($urandom, 4'($urandom_range(0, 15)), $urandom);
            end
        end
        idle(2);
        compare_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
